// File: rtl/uart_pkg.sv
// Shared encodings and sample points for the oversampling UART receiver.
// UART_RX_PARITY_EN adds the PARITY state for the even-parity build.
package uart_pkg;

    localparam int OS_RATE = 16;
    localparam int CNT_W   = $clog2(OS_RATE);

    localparam logic [CNT_W-1:0] SMP_A   = CNT_W'(7);
    localparam logic [CNT_W-1:0] SMP_B   = CNT_W'(8);
    localparam logic [CNT_W-1:0] SMP_C   = CNT_W'(9);
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(OS_RATE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    function automatic logic maj3(input logic a,
                                  input logic b,
                                  input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-cycle TICK every OS_DIV clocks.
import uart_pkg::*;

module uart_baud_tick #(
    parameter logic [15:0] OS_DIV = 16'd163
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    output logic TICK
);

    logic [15:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt  <= 16'd0;
            TICK <= 1'b0;
        end else if (cnt == OS_DIV - 16'd1) begin
            cnt  <= 16'd0;
            TICK <= 1'b1;
        end else begin
            cnt  <= cnt + 16'd1;
            TICK <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority vote and sticky errors.
// Define UART_RX_PARITY_EN to expect an even parity bit after bit 7.
import uart_pkg::*;

module uart_rx_os #(
    parameter logic [15:0] OS_DIV = 16'd163
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    input  logic       CLR_ERR,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       PARITY_ERR
);

    logic             rx_s1;
    logic             rx_s2;
    logic             tick;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             v_a;
    logic             v_b;
    logic             armed;
    logic             bit_val;
    logic             decide;
    logic             good_stop;
    logic             load;
    logic             ovr_set;
    logic             frame_set;

    uart_baud_tick #(.OS_DIV(OS_DIV)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .TICK     (tick)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_set;
`endif

    always_comb begin
        bit_val   = maj3(v_a, v_b, rx_s2);
        decide    = tick && (cnt == SMP_C);
        frame_set = decide && (state == STOP) && !bit_val;
        good_stop = decide && (state == STOP) && bit_val;
`ifdef UART_RX_PARITY_EN
        good_stop = good_stop && !par_bad;
        par_set   = decide && (state == PARITY) && (bit_val != ^shreg);
`endif
        load      = good_stop && (!RX_VALID || RX_READY);
        ovr_set   = good_stop && !load;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            v_a       <= 1'b1;
            v_b       <= 1'b1;
            armed     <= 1'b0;
            RX_DATA   <= 8'h00;
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            if (load) begin
                RX_DATA  <= shreg;
                RX_VALID <= 1'b1;
            end else if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end

            if (frame_set)    FRAME_ERR <= 1'b1;
            else if (CLR_ERR) FRAME_ERR <= 1'b0;

            if (ovr_set)      OVERRUN <= 1'b1;
            else if (CLR_ERR) OVERRUN <= 1'b0;

`ifdef UART_RX_PARITY_EN
            if (par_set)      PARITY_ERR <= 1'b1;
            else if (CLR_ERR) PARITY_ERR <= 1'b0;
`endif

            if (tick) begin
                if (cnt == SMP_A) v_a <= rx_s2;
                if (cnt == SMP_B) v_b <= rx_s2;

                unique case (state)
                    IDLE: begin
                        if (rx_s2) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == SMP_C && bit_val) begin
                            state <= IDLE;
                        end else if (cnt == BIT_END) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == SMP_C)
                            shreg <= {bit_val, shreg[7:1]};
                        if (cnt == BIT_END) begin
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == SMP_C)
                            par_bad <= (bit_val != ^shreg);
                        if (cnt == BIT_END)
                            state <= STOP;
                    end
`endif
                    // Leave at mid-stop so the next start edge is never missed
                    STOP: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == SMP_C)
                            state <= bit_val ? IDLE : WAIT_HIGH;
                    end
                    WAIT_HIGH: begin
                        if (rx_s2)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os at OS_DIV=4 (64 clocks per bit).
`timescale 1ns/1ps
import uart_pkg::*;

module tb_uart_rx_os;

    localparam logic [15:0] DIV = 16'd4;
    localparam int          BIT = 64;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       RX       = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY = 1'b0;
    logic       CLR_ERR  = 1'b0;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       PARITY_ERR;

    int errors = 0;
    int checks = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         fe_rises = 0;
    logic       fe_q     = 1'b0;
    logic       hold_q   = 1'b0;
    logic [7:0] data_q   = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    uart_rx_os #(.OS_DIV(DIV)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .RX         (RX),
        .RX_DATA    (RX_DATA),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
        .CLR_ERR    (CLR_ERR),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN),
        .PARITY_ERR (PARITY_ERR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Consumer side: record accepted bytes, count frame-error onsets,
    // and require RX_DATA to hold while a byte waits unaccepted.
    always @(negedge CLOCK_50) begin
        if (hold_q && RX_VALID) begin
            checks++;
            if (RX_DATA !== data_q) begin
                errors++;
                $display("FAIL data_hold: got %h want %h", RX_DATA, data_q);
            end
        end
        if (RX_VALID && RX_READY)
            got.push_back(RX_DATA);
        if (FRAME_ERR === 1'b1 && !fe_q)
            fe_rises++;
        fe_q   = (FRAME_ERR === 1'b1);
        hold_q = RX_VALID && !RX_READY;
        data_q = RX_DATA;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int len);
        RX = b;
        step(len);
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        step(n);
    endtask

    // Leaves RX at the stop-bit level
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int len);
        drive_bit(1'b0, len);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i], len);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip, len);
`endif
        drive_bit(stop, len);
    endtask

    task automatic pulse_clr();
        CLR_ERR = 1'b1;
        step(1);
        CLR_ERR = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        RX = 1'b1;
        step(3);
        checks++;
        if (RX_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", RX_DATA);
        end
        checks++;
        if (RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", RX_VALID);
        end
        checks++;
        if ({FRAME_ERR, OVERRUN, PARITY_ERR} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {FRAME_ERR, OVERRUN, PARITY_ERR});
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE);
        end
        RESET_N = 1'b1;
        idle(2 * BIT);
    endtask

    task automatic test_basic();
        RX_READY = 1'b1;
        got.delete();
        exp_q = '{8'h55, 8'hA3};
        foreach (exp_q[i]) begin
            send_frame(exp_q[i], 1'b1, BIT);
            idle(BIT);
        end
        checks++;
        if (got.size() !== 2) begin
            errors++;
            $display("FAIL basic_count: got %0d want 2", got.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_byte%0d: got %h want %h",
                             i, got[i], exp_q[i]);
                end
            end
        end
        checks++;
        if ({FRAME_ERR, OVERRUN, PARITY_ERR} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: got %b want 000",
                     {FRAME_ERR, OVERRUN, PARITY_ERR});
        end
    endtask

    task automatic test_glitch();
        got.delete();
        drive_bit(1'b0, 2 * int'(DIV));
        idle(3 * BIT);
        checks++;
        if (got.size() !== 0 || RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL glitch_valid: got %0d bytes valid=%b want 0",
                     got.size(), RX_VALID);
        end
        checks++;
        if ({FRAME_ERR, OVERRUN, PARITY_ERR} !== 3'b000) begin
            errors++;
            $display("FAIL glitch_flags: got %b want 000",
                     {FRAME_ERR, OVERRUN, PARITY_ERR});
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL glitch_state: got %0d want %0d", dut.state, IDLE);
        end
    endtask

    task automatic test_overrun();
        RX_READY = 1'b0;
        got.delete();
        send_frame(8'h12, 1'b1, BIT);
        send_frame(8'h34, 1'b1, BIT);
        idle(BIT);
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'h12) begin
            errors++;
            $display("FAIL ovr_hold: got valid=%b data=%h want 1 12",
                     RX_VALID, RX_DATA);
        end
        checks++;
        if (OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag: got %b want 1", OVERRUN);
        end
        pulse_clr();
        step(1);
        checks++;
        if (OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: got %b want 0", OVERRUN);
        end
        RX_READY = 1'b1;
        step(2);
        checks++;
        if (RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain_valid: got %b want 0", RX_VALID);
        end
        checks++;
        if (got.size() !== 1 || got[0] !== 8'h12) begin
            errors++;
            $display("FAIL ovr_drain_byte: got %0d bytes want one 12",
                     got.size());
        end
    endtask

    task automatic test_frame();
        int base;
        RX_READY = 1'b1;
        got.delete();
        base = fe_rises;
        send_frame(8'h7E, 1'b0, BIT);
        drive_bit(1'b0, 30 * BIT);
        checks++;
        if (FRAME_ERR !== 1'b1 || fe_rises - base !== 1) begin
            errors++;
            $display("FAIL frame_flag: got fe=%b onsets=%0d want 1 1",
                     FRAME_ERR, fe_rises - base);
        end
        checks++;
        if (got.size() !== 0 || RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL frame_discard: got %0d bytes want 0", got.size());
        end
        checks++;
        if (dut.state !== WAIT_HIGH) begin
            errors++;
            $display("FAIL frame_break: got state %0d want %0d",
                     dut.state, WAIT_HIGH);
        end
        idle(BIT);
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL frame_resync: got state %0d want %0d",
                     dut.state, IDLE);
        end
        pulse_clr();
        step(1);
        checks++;
        if (FRAME_ERR !== 1'b0) begin
            errors++;
            $display("FAIL frame_clear: got %b want 0", FRAME_ERR);
        end
        send_frame(8'h01, 1'b1, BIT);
        idle(BIT);
        checks++;
        if (got.size() !== 1 || got[0] !== 8'h01 || FRAME_ERR !== 1'b0) begin
            errors++;
            $display("FAIL frame_next: got %0d bytes fe=%b want one 01 fe=0",
                     got.size(), FRAME_ERR);
        end
    endtask

    task automatic test_reset_mid();
        RX_READY = 1'b1;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++)
            drive_bit(1'b1, BIT);
        step(BIT / 2);
        RESET_N = 1'b0;
        step(1);
        checks++;
        if ({RX_DATA, RX_VALID, FRAME_ERR, OVERRUN, PARITY_ERR} !== 12'h000)
        begin
            errors++;
            $display("FAIL midreset_out: got %h/%b%b%b%b want all 0",
                     RX_DATA, RX_VALID, FRAME_ERR, OVERRUN, PARITY_ERR);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL midreset_state: got %0d want %0d", dut.state, IDLE);
        end
        step(3);
        RESET_N = 1'b1;
        idle(2 * BIT);
        got.delete();
        send_frame(8'h0F, 1'b1, BIT);
        idle(BIT);
        checks++;
        if (got.size() !== 1 || got[0] !== 8'h0F) begin
            errors++;
            $display("FAIL midreset_next: got %0d bytes want one 0F",
                     got.size());
        end
    endtask

    task automatic test_back_to_back();
        RX_READY = 1'b1;
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            int         len;
            d   = 8'($urandom);
            len = int'($urandom_range(BIT - 1, BIT + 1));
            exp_q.push_back(d);
            send_frame(d, 1'b1, len);
            idle(int'($urandom_range(0, 100)));
        end
        idle(BIT);
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d want %0d",
                     got.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_byte%0d: got %h want %h",
                             i, got[i], exp_q[i]);
                end
            end
        end
        checks++;
        if ({FRAME_ERR, OVERRUN, PARITY_ERR} !== 3'b000) begin
            errors++;
            $display("FAIL rand_flags: got %b want 000",
                     {FRAME_ERR, OVERRUN, PARITY_ERR});
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        RX_READY = 1'b1;
        got.delete();
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1, BIT);
        idle(BIT);
        checks++;
        if (PARITY_ERR !== 1'b1) begin
            errors++;
            $display("FAIL par_flag: got %b want 1", PARITY_ERR);
        end
        checks++;
        if (got.size() !== 0 || RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL par_discard: got %0d bytes want 0", got.size());
        end
        pulse_clr();
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1, BIT);
        idle(BIT);
        checks++;
        if (got.size() !== 1 || got[0] !== 8'h03 || PARITY_ERR !== 1'b0) begin
            errors++;
            $display("FAIL par_good: got %0d bytes perr=%b want one 03 perr=0",
                     got.size(), PARITY_ERR);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_overrun();
        test_frame();
        test_reset_mid();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter OS_DIV, default 16'd163, CLOCK_50 cycles per 1/16 bit (50 MHz / (19200*16), rounded).
REQ-002 SHALL have port CLOCK_50  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-004 SHALL have port RX  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port RX_DATA  output  8  received byte, valid while RX_VALID=1.
REQ-006 SHALL have port RX_VALID  output  1  byte available in holding register.
REQ-007 SHALL have port RX_READY  input  1  consumer accepts byte this cycle.
REQ-008 SHALL have port CLR_ERR  input  1  synchronous clear of sticky error flags.
REQ-009 SHALL have port FRAME_ERR  output  1  sticky, stop bit sampled low.
REQ-010 SHALL have port OVERRUN  output  1  sticky, byte dropped because holding register full.
REQ-011 SHALL have port PARITY_ERR  output  1  sticky, parity mismatch (constant 0 when parity disabled).

Function
REQ-012 SHALL pass RX through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL generate a one-cycle tick every OS_DIV clocks from a free-running counter that wraps OS_DIV-1 -> 0.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH, advancing only on ticks.
REQ-015 SHALL, in IDLE, move to START with sample count 0 on the first tick seeing RX low.
REQ-016 SHALL, per bit, count ticks 0..15, sample at ticks 7, 8 and 9, and decide by 2-of-3 majority at tick 9.
REQ-017 SHALL return START to IDLE (false start, no flag) if start majority is high; else enter DATA at tick 15.
REQ-018 SHALL shift 8 data bits LSB first, each decided at tick 9, advancing on tick 15 after bit 7.
REQ-019 SHALL, in STOP, decide at tick 9 and leave STOP on that tick, giving half-bit resync margin.
REQ-020 SHALL on stop high with no error: load RX_DATA and set RX_VALID on the decision edge if RX_VALID=0, or if RX_VALID=1 and RX_READY=1 that cycle.
REQ-021 SHALL otherwise keep the old byte, drop the new one and set OVERRUN.
REQ-022 SHALL on stop low set FRAME_ERR, discard byte, enter WAIT_HIGH, and return to IDLE only on a tick seeing RX high (break holds off restart).
REQ-023 SHALL clear RX_VALID on the edge after RX_VALID&RX_READY unless a new byte loads on that edge.
REQ-024 SHALL ignore RX_READY while RX_VALID=0.
REQ-025 SHALL give CLR_ERR priority below a same-cycle set: flag set wins.
REQ-026 SHALL keep RX_DATA stable while RX_VALID=1.

Reset
REQ-027 SHALL on RESET_N low, at any time including mid-frame, force IDLE, synchronizer flops to 1, tick and bit counters to 0, RX_DATA=8'h00, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, PARITY_ERR=0.
REQ-028 SHALL, after reset release, not start a frame until RX is seen high then low.

Configuration
REQ-029 SHALL, with macro UART_RX_PARITY_EN defined, expect an even parity bit after bit 7 (state PARITY, majority at tick 9); mismatch sets PARITY_ERR and discards the byte, but STOP is still checked.
REQ-030 SHALL, without UART_RX_PARITY_EN, go DATA -> STOP directly and tie PARITY_ERR to 0.

Structure
REQ-031 SHALL place the state encoding, OS_RATE=16, sample indices 7/8/9 and bit-end index 15 in shared package uart_pkg.
REQ-032 SHALL place the tick generator in sub-module uart_baud_tick (OS_DIV parameter, CLOCK_50, RESET_N, TICK output).

Verification
REQ-033 SHALL cover: OS_DIV=4, frame 0x55 then 0xA3, RX_READY=1 -> RX_VALID pulses with 0x55 then 0xA3; no flags set.
REQ-034 SHALL cover: 2-tick low glitch on idle RX -> no RX_VALID, no flags, FSM back in IDLE.
REQ-035 SHALL cover: 0x12 then 0x34 with RX_READY=0 -> RX_DATA stays 0x12 and OVERRUN=1; CLR_ERR pulse -> OVERRUN=0.
REQ-036 SHALL cover: 0x7E with stop bit low, then RX low 30 bit times -> single FRAME_ERR, no restart until RX high; next 0x01 received.
REQ-037 SHALL cover: RESET_N low at data bit 4 of 0xFF -> all outputs 0; next 0x0F received correctly.
REQ-038 SHALL cover: with UART_RX_PARITY_EN, 0x03 with parity 1 -> PARITY_ERR=1, RX_VALID stays 0; 0x03 with parity 0 -> RX_DATA=0x03.
